// File: rtl/cond_exec_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cond_exec_stage_pkg
// Description : Shared types and constants for the conditional-execution
//               stage: condition-code encoding, flag bit positions and the
//               architectural flag-vector type.
// Revision    : 1.0 - initial release
// ============================================================================
package cond_exec_stage_pkg;

  // Condition field encoding; NV is reserved and never passes.
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  // Bit positions inside the {N,Z,C,V} flag vector.
  localparam int c_FLAG_N = 3;
  localparam int c_FLAG_Z = 2;
  localparam int c_FLAG_C = 1;
  localparam int c_FLAG_V = 0;

  typedef logic [3:0] flags_t;

endpackage
`default_nettype wire

// File: rtl/cond_exec_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : cond_exec_stage_if
// Description : Upstream (ALU side) and downstream (writeback/memory side)
//               signals of the conditional-execution stage. The stage uses
//               the slave view; the producer/consumer pair uses master.
// Revision    : 1.0 - initial release
// ============================================================================
interface cond_exec_stage_if
  import cond_exec_stage_pkg::*;
#(
  parameter int DATA_W = 32
);

  // Upstream instruction / ALU result
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        cond;
  logic [1:0]        flagW;
  logic              pcs;
  logic              regW;
  logic              memW;
  logic              noWrite;
  logic [DATA_W-1:0] aluResult;
  flags_t            aluFlags;

  // Downstream pipeline slot
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              pcSrc;
  logic              regWrite;
  logic              memWrite;

  modport master (
    output in_valid, cond, flagW, pcs, regW, memW, noWrite, aluResult, aluFlags,
    output out_ready,
    input  in_ready,
    input  out_valid, out_result, pcSrc, regWrite, memWrite
  );

  modport slave (
    input  in_valid, cond, flagW, pcs, regW, memW, noWrite, aluResult, aluFlags,
    input  out_ready,
    output in_ready,
    output out_valid, out_result, pcSrc, regWrite, memWrite
  );

endinterface
`default_nettype wire

// File: rtl/cond_exec_stage_cond_check.sv
`default_nettype none
// ============================================================================
// Module      : cond_exec_stage_cond_check
// Description : Purely combinational evaluation of a 4-bit condition code
//               against an {N,Z,C,V} flag vector.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_exec_stage_cond_check
  import cond_exec_stage_pkg::*;
(
  input  logic [3:0] i_cond,
  input  flags_t     i_flags,
  output logic       o_cond_ex
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_flags[c_FLAG_N];
  assign w_z = i_flags[c_FLAG_Z];
  assign w_c = i_flags[c_FLAG_C];
  assign w_v = i_flags[c_FLAG_V];

  // Decode the condition field; the reserved encoding never passes.
  always_comb begin
    o_cond_ex = 1'b0;
    case (i_cond)
      COND_EQ: o_cond_ex = w_z;
      COND_NE: o_cond_ex = ~w_z;
      COND_CS: o_cond_ex = w_c;
      COND_CC: o_cond_ex = ~w_c;
      COND_MI: o_cond_ex = w_n;
      COND_PL: o_cond_ex = ~w_n;
      COND_VS: o_cond_ex = w_v;
      COND_VC: o_cond_ex = ~w_v;
      COND_HI: o_cond_ex = w_c & ~w_z;
      COND_LS: o_cond_ex = ~w_c | w_z;
      COND_GE: o_cond_ex = (w_n == w_v);
      COND_LT: o_cond_ex = (w_n != w_v);
      COND_GT: o_cond_ex = ~w_z & (w_n == w_v);
      COND_LE: o_cond_ex = w_z | (w_n != w_v);
      COND_AL: o_cond_ex = 1'b1;
      default: o_cond_ex = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cond_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : cond_exec_stage
// Description : Conditional-execution stage behind the ALU. Evaluates the
//               condition code against the architectural flags, gates the
//               PC/register/memory write enables, updates the flags and
//               registers the result into a one-entry valid/ready slot.
//               Condition-failed instructions are counted (saturating).
// Revision    : 1.0 - initial release
// ============================================================================
module cond_exec_stage
  import cond_exec_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  cond_exec_stage_if.slave bus,
  output flags_t           flags,
  output logic [CNT_W-1:0] squashCount
);

  logic              w_accept;
  logic              w_cond_ex;

  logic              r_valid;
  logic [DATA_W-1:0] r_result;
  logic              r_pc_src;
  logic              r_reg_write;
  logic              r_mem_write;
  flags_t            r_flags;
  logic [CNT_W-1:0]  r_squash_cnt;

  // The slot can take a new instruction when empty or draining this cycle.
  assign bus.in_ready = ~r_valid | bus.out_ready;
  assign w_accept     = bus.in_valid & bus.in_ready;

  // Condition is judged on the registered flags only; aluFlags of the same
  // instruction never feed back into its own condition.
  cond_exec_stage_cond_check u_cond_check (
    .i_cond    (bus.cond),
    .i_flags   (r_flags),
    .o_cond_ex (w_cond_ex)
  );

  // Pipeline slot: load on accept, empty on drain without refill, else hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid     <= 1'b0;
      r_result    <= '0;
      r_pc_src    <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (w_accept) begin
      r_valid     <= 1'b1;
      r_result    <= bus.aluResult;
      r_pc_src    <= bus.pcs & w_cond_ex;
      r_reg_write <= bus.regW & w_cond_ex & ~bus.noWrite;
      r_mem_write <= bus.memW & w_cond_ex;
    end else if (bus.out_ready) begin
      r_valid     <= 1'b0;
    end
  end

  // Architectural flags: only a passing accepted instruction may write them,
  // N/Z and C/V under separate enables.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flags <= '0;
    end else if (w_accept && w_cond_ex) begin
      if (bus.flagW[1]) begin
        r_flags[c_FLAG_N] <= bus.aluFlags[c_FLAG_N];
        r_flags[c_FLAG_Z] <= bus.aluFlags[c_FLAG_Z];
      end
      if (bus.flagW[0]) begin
        r_flags[c_FLAG_C] <= bus.aluFlags[c_FLAG_C];
        r_flags[c_FLAG_V] <= bus.aluFlags[c_FLAG_V];
      end
    end
  end

  // Debug counter of squashed instructions, sticking at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_squash_cnt <= '0;
    end else if (w_accept && !w_cond_ex && (r_squash_cnt != {CNT_W{1'b1}})) begin
      r_squash_cnt <= r_squash_cnt + CNT_W'(1);
    end
  end

  assign bus.out_valid  = r_valid;
  assign bus.out_result = r_result;
  assign bus.pcSrc      = r_pc_src;
  assign bus.regWrite   = r_reg_write;
  assign bus.memWrite   = r_mem_write;
  assign flags          = r_flags;
  assign squashCount    = r_squash_cnt;

endmodule
`default_nettype wire

// File: doc/cond_exec_stage.md
Name: cond_exec_stage

Overview:
- Conditional-execution stage directly downstream of the 32-bit ALU.
- Consumes the ALU result and its {N,Z,C,V} flag vector, holds the architectural flag register, and evaluates the instruction's 4-bit condition code against the current flags.
- Gates PC-source, register-write and memory-write enables, then registers everything into a one-entry valid/ready pipeline slot that feeds writeback/memory.
- Counts condition-failed (squashed) instructions for debug.

Parameters:
- DATA_W, 32, width of ALU result carried through the stage.
- CNT_W, 16, width of the squash counter (saturating).

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream instruction/ALU result present.
- in_ready  out  1  stage can accept this cycle.
- cond  in  4  condition field of the instruction.
- flagW  in  2  flag-write enables: [1] updates N,Z; [0] updates C,V.
- pcs  in  1  instruction writes PC.
- regW  in  1  instruction writes register file.
- memW  in  1  instruction writes memory.
- noWrite  in  1  compare-type op: suppress regWrite.
- aluResult  in  DATA_W  ALU result.
- aluFlags  in  4  {N,Z,C,V} from ALU, same cycle as aluResult.
- out_valid  out  1  output slot holds an instruction.
- out_ready  in  1  downstream accepts the slot.
- out_result  out  DATA_W  registered aluResult.
- pcSrc  out  1  registered, gated pcs.
- regWrite  out  1  registered, gated regW.
- memWrite  out  1  registered, gated memW.
- flags  out  4  architectural flag register {N,Z,C,V}.
- squashCount  out  CNT_W  number of accepted instructions whose condition failed.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_result=0, pcSrc=0, regWrite=0, memWrite=0, flags=4'b0000, squashCount=0. Reset mid-transfer discards the slot; no partial update survives.
- Handshake: in_ready = ~out_valid | out_ready, combinational. accept = in_valid & in_ready.
- Input fields must be held stable while in_valid=1 and in_ready=0.
- condEx is combinational from cond and the registered flags (pre-update values), never from aluFlags:
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N.
  - 0110 VS V; 0111 VC ~V; 1000 HI C&~Z; 1001 LS ~C|Z.
  - 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 is reserved and evaluates to 0 (never).
- On accept, at the clock edge:
  - out_valid<=1; out_result<=aluResult.
  - pcSrc<=pcs&condEx; regWrite<=regW&condEx&~noWrite; memWrite<=memW&condEx.
  - If condEx: flags[3:2]<=aluFlags[3:2] when flagW[1]; flags[1:0]<=aluFlags[1:0] when flagW[0].
  - If ~condEx: flags unchanged; squashCount increments, saturating at all-ones.
- No accept and out_ready=1: out_valid<=0. Enables need not clear, but consumers qualify them with out_valid.
- No accept and out_ready=0: slot holds all values.
- Latency is 1 cycle input-to-output. Throughput is 1/cycle when out_ready stays high.
- Back-to-back: an instruction accepted at edge k evaluates its condition against flags written at edge k-1. There is no bypass of aluFlags.
- Simultaneous out_ready and in_valid while full: the slot drains and refills in the same edge, with no bubble.
- flags only changes on an accepted, condition-passing instruction with a nonzero flagW.

Decomposition:
- Shared package: condition-code enum (EQ..AL, NV), flag bit indices (N=3, Z=2, C=1, V=0), flag-vector typedef.
- Sub-module cond_check: purely combinational cond × flags -> condEx; reused by a future branch predictor.

Test Plan:
- Reset then idle: after reset_n low→high with in_valid=0, all outputs 0, in_ready=1.
- Flag write then EQ: accept cond=AL, flagW=11, aluFlags=0100, regW=1 → regWrite=1, flags=0100. Next accept cond=EQ, memW=1 → memWrite=1.
- Squash: flags=0100, accept cond=NE, pcs=1, regW=1, flagW=11, aluFlags=1000 → pcSrc=0, regWrite=0, flags stay 0100, squashCount=1.
- Signed compare: flags=1000 (N=1, V=0), cond=LT → pass; cond=GE → fail. Flags=1001 → GE passes.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → slot holds the first result (e.g. 0xDEADBEEF), in_ready=0. Release gives in-order, lossless delivery.
- Saturation and mid-op reset: with CNT_W=2, 5 failing instructions → squashCount=3. Asserting reset_n=0 with out_valid=1 clears all outputs asynchronously, before the next edge.
